// File: rtl/branch_history_table_206.sv
// Fetch-side branch predictor: a table of 2-bit saturating counters that is swept
// to weak not-taken after reset, then trained by resolved branches. It also keeps hit/miss statistics.
module branch_history_table_206 #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PredPC,
    output logic        PredTaken,
    output logic        Ready,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic        UpdTaken,
    input  logic        UpdPredTaken,
    output logic        Mispredict,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
);

    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic               ready_q, ready_d;
    logic               mispredict_q, mispredict_d;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        misp_cnt_q, misp_cnt_d;

    logic [1:0]         table_q [DEPTH];

    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic               upd_fire;
    logic               upd_miss;
    logic [1:0]         upd_ctr;
    logic [1:0]         upd_ctr_next;

    // Word-aligned PCs: the two low bits never select an entry.
    assign pred_idx = PredPC[INDEX_W+1:2];
    assign upd_idx  = UpdPC[INDEX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PredPC[31:INDEX_W+2], PredPC[1:0], UpdPC[31:INDEX_W+2], UpdPC[1:0]};

    assign upd_fire = (state_q == ST_RUN) && UpdValid;
    assign upd_miss = upd_fire && (UpdTaken != UpdPredTaken);
    assign upd_ctr  = table_q[upd_idx];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (UpdTaken) begin
            if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mispredict_d = 1'b0;
        branch_cnt_d = branch_cnt_q;
        misp_cnt_d   = misp_cnt_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + INDEX_W'(1);
                if (ptr_q == {INDEX_W{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN: begin
                mispredict_d = upd_miss;
                if (upd_fire) branch_cnt_d = branch_cnt_q + 32'd1;
                if (upd_miss) misp_cnt_d = misp_cnt_q + 32'd1;
            end
            default: state_d = ST_INIT;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            ready_q      <= 1'b0;
            mispredict_q <= 1'b0;
            branch_cnt_q <= 32'd0;
            misp_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            mispredict_q <= mispredict_d;
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    // Table has no reset of its own; the INIT sweep defines every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                table_q[ptr_q] <= 2'b01;
            end else if (upd_fire) begin
                table_q[upd_idx] <= upd_ctr_next;
            end
        end
    end

    assign PredTaken       = ready_q & table_q[pred_idx][1];
    assign Ready           = ready_q;
    assign Mispredict      = mispredict_q;
    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = misp_cnt_q;

endmodule

// File: tb/tb_branch_history_table_206.sv
// Randomised and directed bench for branch_history_table_206 against a counter-table model.
module tb_branch_history_table_206;

  logic        clk;
  logic        rst;
  logic [31:0] PredPC;
  logic        PredTaken;
  logic        Ready;
  logic        UpdValid;
  logic [31:0] UpdPC;
  logic        UpdTaken;
  logic        UpdPredTaken;
  logic        Mispredict;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counter values 0..3 per entry, sweep length counted in edges.
  int          m_tbl [64];
  int          m_init_edges;
  bit          m_run;
  logic [31:0] m_bc;
  logic [31:0] m_mc;
  bit          m_misp;

  branch_history_table_206 dut (
    .clk(clk),
    .rst(rst),
    .PredPC(PredPC),
    .PredTaken(PredTaken),
    .Ready(Ready),
    .UpdValid(UpdValid),
    .UpdPC(UpdPC),
    .UpdTaken(UpdTaken),
    .UpdPredTaken(UpdPredTaken),
    .Mispredict(Mispredict),
    .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit exp_pred(input logic [31:0] pc);
    return m_run && (m_tbl[pc_idx(pc)] >= 2);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_init_edges = 0; m_bc = 0; m_mc = 0; m_misp = 0;
    end else if (!m_run) begin
      m_misp = 0;
      m_init_edges++;
      if (m_init_edges == 64) begin
        m_run = 1;
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
      end
    end else begin
      m_misp = UpdValid && (UpdTaken != UpdPredTaken);
      if (UpdValid) begin
        if (UpdTaken) m_tbl[pc_idx(UpdPC)] = (m_tbl[pc_idx(UpdPC)] == 3) ? 3 : m_tbl[pc_idx(UpdPC)] + 1;
        else          m_tbl[pc_idx(UpdPC)] = (m_tbl[pc_idx(UpdPC)] == 0) ? 0 : m_tbl[pc_idx(UpdPC)] - 1;
        m_bc = m_bc + 32'd1;
        if (UpdTaken != UpdPredTaken) m_mc = m_mc + 32'd1;
      end
    end
  endtask

  // Driver: advance one edge with the current inputs; outputs are sampled 1ns after.
  task automatic do_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic ptaken);
    UpdPC = pc; UpdTaken = taken; UpdPredTaken = ptaken; UpdValid = 1'b1;
    do_edge();
    UpdValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; UpdValid = 1'b0; PredPC = 32'h0; UpdPC = 32'h0; UpdTaken = 1'b0; UpdPredTaken = 1'b0;
    do_edge();
    do_edge();
    n_checks++;
    if (Ready !== 1'b0 || Mispredict !== 1'b0 || BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state: Ready=%b Mispredict=%b BranchCount=%0d MispredictCount=%0d want 0/0/0/0",
               Ready, Mispredict, BranchCount, MispredictCount);
    end
    rst = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      // Updates presented during the sweep must be ignored.
      UpdValid = 1'b1; UpdPC = $urandom; UpdTaken = $urandom_range(0, 1); UpdPredTaken = ~UpdTaken;
      PredPC = $urandom;
      #1;
      n_checks++;
      if (PredTaken !== 1'b0) begin
        n_errors++;
        $display("FAIL init_predtaken: edge %0d got %b want 0", e, PredTaken);
      end
      do_edge();
      n_checks++;
      if (Ready !== (e == 64)) begin
        n_errors++;
        $display("FAIL init_ready: edge %0d got %b want %b", e, Ready, (e == 64));
      end
      n_checks++;
      if (Mispredict !== 1'b0 || BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
        n_errors++;
        $display("FAIL init_ignore_upd: edge %0d Mispredict=%b BranchCount=%0d MispredictCount=%0d want 0",
                 e, Mispredict, BranchCount, MispredictCount);
      end
    end
    UpdValid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] pc = 32'h0040_0010;
    bit          seq_taken [7] = '{1, 1, 1, 0, 0, 0, 0};
    bit          seq_exp   [7] = '{1, 1, 1, 1, 0, 0, 0};
    PredPC = pc;
    for (int i = 0; i < 7; i++) begin
      train(pc, seq_taken[i], seq_taken[i]);
      n_checks++;
      if (PredTaken !== seq_exp[i] || PredTaken !== exp_pred(pc)) begin
        n_errors++;
        $display("FAIL saturation: step %0d got %b want %b", i, PredTaken, seq_exp[i]);
      end
    end
    // Counter is at 00 here; one taken brings it to 01 only, not 10.
    train(pc, 1'b1, 1'b1);
    n_checks++;
    if (PredTaken !== 1'b0) begin
      n_errors++;
      $display("FAIL saturation_floor: got %b want 0", PredTaken);
    end
  endtask

  task automatic test_aliasing();
    train(32'h0040_0004, 1'b1, 1'b0);
    PredPC = 32'h0040_0104;
    #1;
    n_checks++;
    if (PredTaken !== 1'b1 || PredTaken !== exp_pred(PredPC)) begin
      n_errors++;
      $display("FAIL alias_shared: got %b want 1", PredTaken);
    end
    PredPC = 32'h0040_0008;
    #1;
    n_checks++;
    if (PredTaken !== 1'b0 || PredTaken !== exp_pred(PredPC)) begin
      n_errors++;
      $display("FAIL alias_independent: got %b want 0", PredTaken);
    end
    train(32'h0040_0104, 1'b0, 1'b1);
    PredPC = 32'h0040_0004;
    #1;
    n_checks++;
    if (PredTaken !== 1'b0) begin
      n_errors++;
      $display("FAIL alias_untrain: got %b want 0", PredTaken);
    end
  endtask

  task automatic test_mispredict();
    logic [31:0] bc0;
    logic [31:0] mc0;
    bc0 = m_bc; mc0 = m_mc;
    train(32'h0040_0030, 1'b1, 1'b0);
    n_checks++;
    if (Mispredict !== 1'b1 || MispredictCount !== mc0 + 32'd1 || BranchCount !== bc0 + 32'd1) begin
      n_errors++;
      $display("FAIL mispredict_pulse: Mispredict=%b MispredictCount=%0d BranchCount=%0d want 1/%0d/%0d",
               Mispredict, MispredictCount, BranchCount, mc0 + 1, bc0 + 1);
    end
    train(32'h0040_0030, 1'b1, 1'b1);
    n_checks++;
    if (Mispredict !== 1'b0 || MispredictCount !== mc0 + 32'd1 || BranchCount !== bc0 + 32'd2) begin
      n_errors++;
      $display("FAIL mispredict_match: Mispredict=%b MispredictCount=%0d BranchCount=%0d want 0/%0d/%0d",
               Mispredict, MispredictCount, BranchCount, mc0 + 1, bc0 + 2);
    end
    do_edge();
    n_checks++;
    if (Mispredict !== 1'b0 || BranchCount !== bc0 + 32'd2) begin
      n_errors++;
      $display("FAIL mispredict_idle: Mispredict=%b BranchCount=%0d want 0/%0d", Mispredict, BranchCount, bc0 + 2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] pc = 32'h0040_0020;
    PredPC = pc; UpdPC = pc; UpdTaken = 1'b1; UpdPredTaken = 1'b0; UpdValid = 1'b1;
    #1;
    n_checks++;
    if (PredTaken !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_before: got %b want 0", PredTaken);
    end
    do_edge();
    UpdValid = 1'b0;
    n_checks++;
    if (PredTaken !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_after: got %b want 1", PredTaken);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      PredPC = {24'h004000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      UpdPC = {24'h004000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      UpdValid = ($urandom_range(0, 3) != 0);
      UpdTaken = $urandom_range(0, 1);
      UpdPredTaken = $urandom_range(0, 1);
      #1;
      n_checks++;
      if (PredTaken !== exp_pred(PredPC)) begin
        n_errors++;
        $display("FAIL random_pred: cycle %0d pc %h got %b want %b", c, PredPC, PredTaken, exp_pred(PredPC));
      end
      do_edge();
      n_checks++;
      if (Ready !== m_run || Mispredict !== m_misp || BranchCount !== m_bc || MispredictCount !== m_mc) begin
        n_errors++;
        $display("FAIL random_stats: cycle %0d got %b/%b/%0d/%0d want %b/%b/%0d/%0d", c, Ready, Mispredict,
                 BranchCount, MispredictCount, m_run, m_misp, m_bc, m_mc);
      end
    end
    UpdValid = 1'b0;
  endtask

  // Reset pulse (optionally with an update pending), then check a fresh full sweep.
  task automatic reset_and_sweep(input string tag);
    UpdValid = 1'b1; UpdPC = 32'h0040_0040; UpdTaken = 1'b1; UpdPredTaken = 1'b0;
    rst = 1'b1;
    do_edge();
    rst = 1'b0;
    n_checks++;
    if (Ready !== 1'b0 || Mispredict !== 1'b0 || BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
      n_errors++;
      $display("FAIL %s_reset: Ready=%b Mispredict=%b BranchCount=%0d MispredictCount=%0d want 0",
               tag, Ready, Mispredict, BranchCount, MispredictCount);
    end
    UpdValid = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      do_edge();
      if (e == 63 || e == 64) begin
        n_checks++;
        if (Ready !== (e == 64)) begin
          n_errors++;
          $display("FAIL %s_sweep_ready: edge %0d got %b want %b", tag, e, Ready, (e == 64));
        end
      end
    end
    // The entry trained before reset is back to weak not-taken.
    PredPC = 32'h0040_0030;
    #1;
    n_checks++;
    if (PredTaken !== 1'b0 || PredTaken !== exp_pred(PredPC)) begin
      n_errors++;
      $display("FAIL %s_table_reinit: got %b want 0", tag, PredTaken);
    end
  endtask

  task automatic test_mid_sweep_reset();
    train(32'h0040_0030, 1'b1, 1'b1);
    train(32'h0040_0030, 1'b1, 1'b1);
    rst = 1'b1;
    do_edge();
    rst = 1'b0;
    for (int e = 0; e < 30; e++) do_edge();
    n_checks++;
    if (Ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_sweep_ready: got %b want 0", Ready);
    end
    reset_and_sweep("mid_sweep");
  endtask

  task automatic test_mid_run_reset();
    for (int i = 0; i < 10; i++) train(32'h0040_0030, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    train(32'h0040_0030, 1'b1, 1'b1);
    train(32'h0040_0030, 1'b1, 1'b1);
    n_checks++;
    if (BranchCount !== m_bc || BranchCount !== 32'd12) begin
      n_errors++;
      $display("FAIL mid_run_count: got %0d want 12", BranchCount);
    end
    reset_and_sweep("mid_run");
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_aliasing();
    test_mispredict();
    test_same_cycle();
    test_random(300);
    test_mid_sweep_reset();
    test_mid_run_reset();
    test_random(100);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
